// File: rtl/pu_riscv_verilog_pkg.sv
// Shared RISC-V execute-stage definitions for the divider.
// Holds the M-extension divide/remainder decode patterns, the XLEN mode
// codes, and the divider FSM state encoding.
package pu_riscv_verilog_pkg;

    // Decode key is {func7, func3, opcode[6:2]}
    localparam int unsigned DEC_W = 15;

    localparam logic [DEC_W-1:0] DIV   = 15'b0000001_100_01100;
    localparam logic [DEC_W-1:0] DIVU  = 15'b0000001_101_01100;
    localparam logic [DEC_W-1:0] REM   = 15'b0000001_110_01100;
    localparam logic [DEC_W-1:0] REMU  = 15'b0000001_111_01100;
    localparam logic [DEC_W-1:0] DIVW  = 15'b0000001_100_01110;
    localparam logic [DEC_W-1:0] DIVUW = 15'b0000001_101_01110;
    localparam logic [DEC_W-1:0] REMW  = 15'b0000001_110_01110;
    localparam logic [DEC_W-1:0] REMUW = 15'b0000001_111_01110;

    // XLEN mode codes (misa.MXL encoding)
    localparam logic [1:0] RV32I  = 2'b01;
    localparam logic [1:0] RV64I  = 2'b10;
    localparam logic [1:0] RV128I = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/pu_riscv_div_step.sv
// One restoring division step.
// Ports:
//   r_i / q_i  partial remainder and quotient/dividend shift register
//   d_i        absolute divisor
//   r_o / q_o  remainder and quotient after shifting {R,Q} left by one and
//              conditionally subtracting the divisor
module pu_riscv_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] r_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] r_o,
    output logic [XLEN-1:0] q_o
);

    // Shifted remainder needs one extra bit: it can reach 2*D-1
    logic [XLEN:0] r_shift;
    logic [XLEN:0] r_diff;

    always_comb begin
        r_shift = {r_i, q_i[XLEN-1]};
        r_diff  = r_shift - {1'b0, d_i};
        if (r_shift >= {1'b0, d_i}) begin
            r_o = r_diff[XLEN-1:0];
            q_o = {q_i[XLEN-2:0], 1'b1};
        end else begin
            r_o = r_shift[XLEN-1:0];
            q_o = {q_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/pu_riscv_divider.sv
// Iterative restoring integer divider for RV32M/RV64M.
// Executes DIV/DIVU/REM/REMU and, when XLEN > 32 and not in RV32I mode,
// DIVW/DIVUW/REMW/REMUW, one quotient bit per cycle.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   ex_stall     pipeline stall, only blocks acceptance
//   id_bubble    instruction slot is empty
//   id_instr     instruction to decode
//   opA, opB     dividend, divisor
//   st_xlen      current XLEN mode
//   div_stall    high while a division is in flight
//   div_bubble   low for one cycle when div_r carries a new result
//   div_r        quotient or remainder, held until the next result
module pu_riscv_divider
    import pu_riscv_verilog_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_stall,
    output logic            div_stall,
    input  logic            id_bubble,
    input  logic [ILEN-1:0] id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            div_bubble,
    output logic [XLEN-1:0] div_r
);

    localparam int unsigned CNT_W   = $clog2(XLEN);
    localparam int unsigned W_ALIGN = XLEN - 32;
    localparam bit          HAS_W   = (XLEN > 32);

    // Most-negative values for the XLEN forms and the sign-extended W forms
    localparam logic [XLEN-1:0] MIN_X = XLEN'(1) << (XLEN - 1);
    localparam logic [XLEN-1:0] MIN_W = ~((XLEN'(1) << 31) - XLEN'(1));

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [DEC_W-1:0] dec_key;
    logic             is_div;
    logic             is_w;
    logic             is_signed;
    logic             is_rem;
    logic             w_ok;
    logic             unused_instr;

    assign dec_key      = {id_instr[31:25], id_instr[14:12], id_instr[6:2]};
    assign w_ok         = HAS_W && (st_xlen != RV32I);
    assign unused_instr = ^id_instr;

    always_comb begin
        is_div    = 1'b0;
        is_w      = 1'b0;
        is_signed = 1'b0;
        is_rem    = 1'b0;
        case (dec_key)
            DIV:  begin is_div = 1'b1; is_signed = 1'b1; end
            DIVU: begin is_div = 1'b1; end
            REM:  begin is_div = 1'b1; is_signed = 1'b1; is_rem = 1'b1; end
            REMU: begin is_div = 1'b1; is_rem = 1'b1; end
            DIVW: begin
                is_div = w_ok; is_w = w_ok; is_signed = 1'b1;
            end
            DIVUW: begin
                is_div = w_ok; is_w = w_ok;
            end
            REMW: begin
                is_div = w_ok; is_w = w_ok; is_signed = 1'b1; is_rem = 1'b1;
            end
            REMUW: begin
                is_div = w_ok; is_w = w_ok; is_rem = 1'b1;
            end
            default: begin
                is_div = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand preparation and special-case detection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] q_init;
    logic            div_zero;
    logic            sgn_ovf;

    always_comb begin
        if (is_w) begin
            a_ext = is_signed ? XLEN'($signed(opA[31:0])) : XLEN'(opA[31:0]);
            b_ext = is_signed ? XLEN'($signed(opB[31:0])) : XLEN'(opB[31:0]);
        end else begin
            a_ext = opA;
            b_ext = opB;
        end
        sign_a   = is_signed & a_ext[XLEN-1];
        sign_b   = is_signed & b_ext[XLEN-1];
        abs_a    = sign_a ? (-a_ext) : a_ext;
        abs_b    = sign_b ? (-b_ext) : b_ext;
        // W forms iterate 32 steps, so park the dividend at the top of Q
        q_init   = is_w ? (abs_a << W_ALIGN) : abs_a;
        div_zero = (b_ext == '0);
        sgn_ovf  = is_signed && (&b_ext) && (a_ext == (is_w ? MIN_W : MIN_X));
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_e      state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [XLEN-1:0] r_q,          r_d;
    logic [XLEN-1:0] q_q,          q_d;
    logic [XLEN-1:0] d_q,          d_d;
    logic            quo_neg_q,    quo_neg_d;
    logic            rem_neg_q,    rem_neg_d;
    logic            sel_rem_q,    sel_rem_d;
    logic            is_w_q,       is_w_d;
    logic            div_stall_q,  div_stall_d;
    logic            div_bubble_q, div_bubble_d;
    logic [XLEN-1:0] div_r_q,      div_r_d;

    logic [XLEN-1:0] step_r;
    logic [XLEN-1:0] step_q;

    pu_riscv_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    // ------------------------------------------------------------------
    // Result: sign correction, quotient/remainder select, W sign-extend
    // ------------------------------------------------------------------
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] sel_val;
    logic [XLEN-1:0] result_c;

    always_comb begin
        quo_fix  = quo_neg_q ? (-q_q) : q_q;
        rem_fix  = rem_neg_q ? (-r_q) : r_q;
        sel_val  = sel_rem_q ? rem_fix : quo_fix;
        result_c = is_w_q ? XLEN'($signed(sel_val[31:0])) : sel_val;
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        r_d          = r_q;
        q_d          = q_q;
        d_d          = d_q;
        quo_neg_d    = quo_neg_q;
        rem_neg_d    = rem_neg_q;
        sel_rem_d    = sel_rem_q;
        is_w_d       = is_w_q;
        div_stall_d  = div_stall_q;
        div_bubble_d = 1'b1;
        div_r_d      = div_r_q;

        case (state_q)
            DIV_IDLE: begin
                if (!ex_stall && !id_bubble && is_div) begin
                    div_stall_d = 1'b1;
                    sel_rem_d   = is_rem;
                    is_w_d      = is_w;
                    d_d         = abs_b;
                    if (div_zero || sgn_ovf) begin
                        // Final values go straight into Q/R, no correction
                        state_d   = DIV_DONE;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        q_d       = div_zero ? '1 : a_ext;
                        r_d       = div_zero ? a_ext : '0;
                    end else begin
                        state_d   = DIV_BUSY;
                        cnt_d     = is_w ? CNT_W'(31) : CNT_W'(XLEN - 1);
                        quo_neg_d = sign_a ^ sign_b;
                        rem_neg_d = sign_a;
                        q_d       = q_init;
                        r_d       = '0;
                    end
                end
            end

            DIV_BUSY: begin
                r_d = step_r;
                q_d = step_q;
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DIV_DONE: begin
                div_r_d      = result_c;
                div_bubble_d = 1'b0;
                div_stall_d  = 1'b0;
                state_d      = DIV_IDLE;
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DIV_IDLE;
            cnt_q        <= '0;
            r_q          <= '0;
            q_q          <= '0;
            d_q          <= '0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            sel_rem_q    <= 1'b0;
            is_w_q       <= 1'b0;
            div_stall_q  <= 1'b0;
            div_bubble_q <= 1'b1;
            div_r_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            r_q          <= r_d;
            q_q          <= q_d;
            d_q          <= d_d;
            quo_neg_q    <= quo_neg_d;
            rem_neg_q    <= rem_neg_d;
            sel_rem_q    <= sel_rem_d;
            is_w_q       <= is_w_d;
            div_stall_q  <= div_stall_d;
            div_bubble_q <= div_bubble_d;
            div_r_q      <= div_r_d;
        end
    end

    assign div_stall  = div_stall_q;
    assign div_bubble = div_bubble_q;
    assign div_r      = div_r_q;

endmodule

// File: tb/tb_pu_riscv_divider.sv
// Directed, table-driven bench for pu_riscv_divider (XLEN=64).
module tb_pu_riscv_divider;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 64;

    localparam logic [4:0] OPC_OP   = 5'b01100;
    localparam logic [4:0] OPC_OP32 = 5'b01110;
    localparam logic [6:0] F7_M     = 7'b0000001;
    localparam logic [1:0] M_RV32   = 2'b01;
    localparam logic [1:0] M_RV64   = 2'b10;

    logic            clk;
    logic            rst;
    logic            ex_stall;
    logic            div_stall;
    logic            id_bubble;
    logic [ILEN-1:0] id_instr;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [1:0]      st_xlen;
    logic            div_bubble;
    logic [XLEN-1:0] div_r;

    int checks;
    int errors;

    pu_riscv_divider #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_stall   (ex_stall),
        .div_stall  (div_stall),
        .id_bubble  (id_bubble),
        .id_instr   (id_instr),
        .opA        (opA),
        .opB        (opB),
        .st_xlen    (st_xlen),
        .div_bubble (div_bubble),
        .div_r      (div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] opc);
        mk = {32'h0, f7, 5'd3, 5'd2, f3, 5'd1, opc, 2'b11};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Issue one operation, then measure latency, stall cycles and result.
    task automatic run_op(input logic [63:0] instr, input logic [63:0] a,
                          input logic [63:0] b, input logic [1:0] xm, input bit tog,
                          output logic [63:0] res, output int lat,
                          output int stall_cnt, output bit tail_ok);
        bit done;
        @(negedge clk);
        id_instr  = instr;
        opA       = a;
        opB       = b;
        st_xlen   = xm;
        ex_stall  = 1'b0;
        id_bubble = 1'b0;
        @(posedge clk);
        #1;
        id_bubble = 1'b1;
        opA       = '1;
        opB       = '0;
        id_instr  = '0;
        lat       = -1;
        stall_cnt = 0;
        res       = '0;
        done      = 1'b0;
        tail_ok   = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (tog) ex_stall = ~ex_stall;
            if (!div_bubble) begin
                lat     = k;
                res     = div_r;
                done    = 1'b1;
                tail_ok = !div_stall;
            end else if (div_stall) begin
                stall_cnt++;
            end
        end
        ex_stall = 1'b0;
        if (done) begin
            @(negedge clk);
            tail_ok = tail_ok && div_bubble && !div_stall;
        end
    endtask

    // Hold a non-accepted request for a few cycles; report whether it stayed idle.
    task automatic hold_idle(input logic [63:0] instr, input logic [1:0] xm,
                             input logic exs, input logic bub, output bit idle_ok);
        @(negedge clk);
        id_instr  = instr;
        opA       = 64'd100;
        opB       = 64'd7;
        st_xlen   = xm;
        ex_stall  = exs;
        id_bubble = bub;
        idle_ok   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (div_stall || !div_bubble) idle_ok = 1'b0;
        end
        id_bubble = 1'b1;
        ex_stall  = 1'b0;
        st_xlen   = M_RV64;
        @(negedge clk);
        if (div_stall || !div_bubble) idle_ok = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [63:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  xm;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [63:0] res;
        int          lat;
        int          scnt;
        bit          tail_ok;
        bit          idle_ok;
        logic [63:0] i_div, i_divu, i_rem, i_remu;
        logic [63:0] i_divw, i_divuw, i_remw, i_remuw, i_add;

        checks = 0;
        errors = 0;

        i_div   = mk(F7_M, 3'b100, OPC_OP);
        i_divu  = mk(F7_M, 3'b101, OPC_OP);
        i_rem   = mk(F7_M, 3'b110, OPC_OP);
        i_remu  = mk(F7_M, 3'b111, OPC_OP);
        i_divw  = mk(F7_M, 3'b100, OPC_OP32);
        i_divuw = mk(F7_M, 3'b101, OPC_OP32);
        i_remw  = mk(F7_M, 3'b110, OPC_OP32);
        i_remuw = mk(F7_M, 3'b111, OPC_OP32);
        i_add   = mk(7'b0000000, 3'b000, OPC_OP);

        vt[0]  = '{"div_neg",     i_div,   -64'sd20, 64'd6, M_RV64, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vt[1]  = '{"rem_neg",     i_rem,   -64'sd20, 64'd6, M_RV64, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vt[2]  = '{"divu_zero",   i_divu,  64'd100, 64'd0, M_RV64, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vt[3]  = '{"remu_zero",   i_remu,  64'h1234, 64'd0, M_RV64, 64'h1234, 1};
        vt[4]  = '{"div_ovf",     i_div,   64'h8000_0000_0000_0000, '1, M_RV64,
                   64'h8000_0000_0000_0000, 1};
        vt[5]  = '{"rem_ovf",     i_rem,   64'h8000_0000_0000_0000, '1, M_RV64, 64'h0, 1};
        vt[6]  = '{"divw_ovf",    i_divw,  64'hDEAD_BEEF_8000_0000, 64'hFFFF_FFFF, M_RV64,
                   64'hFFFF_FFFF_8000_0000, 1};
        vt[7]  = '{"remuw",       i_remuw, 64'hFFFF_FFFF_0000_0007, 64'd3, M_RV64, 64'd1, 33};
        vt[8]  = '{"divu",        i_divu,  64'd100, 64'd7, M_RV64, 64'd14, 65};
        vt[9]  = '{"rem_negdiv",  i_rem,   64'd20, -64'sd6, M_RV64, 64'd2, 65};
        vt[10] = '{"divuw",       i_divuw, 64'h0000_0001_FFFF_FFFE, 64'd2, M_RV64,
                   64'h7FFF_FFFF, 33};
        vt[11] = '{"divw_neg",    i_divw,  64'h1234_5678_FFFF_FFEC, 64'd6, M_RV64,
                   64'hFFFF_FFFF_FFFF_FFFD, 33};
        vt[12] = '{"remw_neg",    i_remw,  64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0006,
                   M_RV64, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vt[13] = '{"divu_big",    i_divu,  '1, 64'h10, M_RV64, 64'h0FFF_FFFF_FFFF_FFFF, 65};
        vt[14] = '{"divw_zero",   i_divw,  64'd5, 64'hFFFF_FFFF_0000_0000, M_RV64, '1, 1};
        vt[15] = '{"remw_zero",   i_remw,  64'h0000_0000_8000_0001, 64'd0, M_RV64,
                   64'hFFFF_FFFF_8000_0001, 1};

        rst       = 1'b1;
        ex_stall  = 1'b0;
        id_bubble = 1'b1;
        id_instr  = '0;
        opA       = '0;
        opB       = '0;
        st_xlen   = M_RV64;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall",  64'(div_stall),  64'd0);
        chk("reset_bubble", 64'(div_bubble), 64'd1);
        chk("reset_r",      div_r,           64'd0);

        foreach (vt[i]) begin
            run_op(vt[i].instr, vt[i].a, vt[i].b, vt[i].xm, 1'b0, res, lat, scnt, tail_ok);
            chk({vt[i].name, "_r"},     res,            vt[i].exp);
            chk({vt[i].name, "_lat"},   64'(lat),       64'(vt[i].lat));
            chk({vt[i].name, "_stall"}, 64'(scnt),      64'(vt[i].lat));
            chk({vt[i].name, "_tail"},  64'(tail_ok),   64'd1);
        end

        // Result holds while idle (last vector result)
        repeat (5) @(negedge clk);
        chk("hold_r", div_r, 64'hFFFF_FFFF_8000_0001);

        // Requests that must not be accepted
        hold_idle(i_div, M_RV64, 1'b1, 1'b0, idle_ok);
        chk("no_acc_ex_stall", 64'(idle_ok), 64'd1);
        hold_idle(i_div, M_RV64, 1'b0, 1'b1, idle_ok);
        chk("no_acc_bubble", 64'(idle_ok), 64'd1);
        hold_idle(i_divw, M_RV32, 1'b0, 1'b0, idle_ok);
        chk("no_acc_rv32_divw", 64'(idle_ok), 64'd1);
        hold_idle(i_add, M_RV64, 1'b0, 1'b0, idle_ok);
        chk("no_acc_add", 64'(idle_ok), 64'd1);
        chk("no_acc_hold_r", div_r, 64'hFFFF_FFFF_8000_0001);

        // ex_stall toggling while busy does not change latency
        run_op(i_div, 64'd1000, 64'd7, M_RV64, 1'b1, res, lat, scnt, tail_ok);
        chk("tog_r",    res,       64'd142);
        chk("tog_lat",  64'(lat),  64'd65);
        chk("tog_tail", 64'(tail_ok), 64'd1);

        // Reset after step 10 aborts the operation
        @(negedge clk);
        id_instr  = i_div;
        opA       = 64'd999;
        opB       = 64'd3;
        st_xlen   = M_RV64;
        id_bubble = 1'b0;
        @(posedge clk);
        #1;
        id_bubble = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_stall_busy", 64'(div_stall), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall",  64'(div_stall),  64'd0);
        chk("rst_mid_bubble", 64'(div_bubble), 64'd1);
        chk("rst_mid_r",      div_r,           64'd0);
        begin
            bit no_result;
            no_result = 1'b1;
            for (int k = 0; k < 70; k++) begin
                @(negedge clk);
                if (!div_bubble || div_stall) no_result = 1'b0;
            end
            chk("rst_mid_no_result", 64'(no_result), 64'd1);
        end

        run_op(i_div, -64'sd20, 64'd6, M_RV64, 1'b0, res, lat, scnt, tail_ok);
        chk("post_rst_r",   res,      64'hFFFF_FFFF_FFFF_FFFD);
        chk("post_rst_lat", 64'(lat), 64'd65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
